// File: rtl/ddr2_i2c_byte_master.sv
// ddr2_i2c_byte_master
//   Avalon-MM controlled I2C byte engine for the DDR2 SPD / thermal-sensor bus.
//   One CMD write performs an optional START, one 8-bit transfer plus ACK bit,
//   and an optional STOP. Each bus phase is split into four quarters whose
//   length is CLKDIV+1 clk cycles; the target may stretch SCL.
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   address[1:0]       0 CMD (wo), 1 STATUS, 2 RXDATA, 3 CLKDIV
//   chipselect,write_n write strobe (chipselect=1 and write_n=0)
//   writedata[31:0]    write data
//   readdata[31:0]     combinational read data, unused bits 0
//   scl_in, sda_in     asynchronous pad inputs
//   scl_oe, sda_oe     1 = pull line low, 0 = release
module ddr2_i2c_byte_master #(
    parameter int unsigned DEFAULT_DIV = 124
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        scl_oe,
    output logic        sda_oe
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BIT, S_STOP} state_t;

    localparam logic [15:0] DIV_RST = 16'(DEFAULT_DIV);
    localparam logic [15:0] DIV_MIN = 16'd4;

    logic        scl_meta, scl_s, sda_meta, sda_s;
    state_t      state, state_n;
    logic [1:0]  q, q_n;
    logic [3:0]  bit_idx, bit_n;
    logic [15:0] cnt, cnt_n;
    logic [15:0] clkdiv;
    logic        busy, busy_n;
    logic [7:0]  tx_byte, tx_n;
    logic        stop_req, stop_n;
    logic        rd_req, rd_n;
    logic        nack_bit, nack_n;
    logic [7:0]  shreg, shreg_n;
    logic [7:0]  rxdata, rxdata_n;
    logic        rx_ack, rx_ack_n;
    logic        scl_oe_n, sda_oe_n;
    logic        wr_en, cmd_wr, div_wr;
    logic        stretch_q, enter;
    logic        unused_wdata;

    assign unused_wdata = ^writedata[31:16];

    assign wr_en  = chipselect & ~write_n;
    assign cmd_wr = wr_en & (address == 2'd0) & ~busy;
    assign div_wr = wr_en & (address == 2'd3) & ~busy;

    // 2-FF synchronisers; idle bus level is high
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_meta <= 1'b1;
            scl_s    <= 1'b1;
            sda_meta <= 1'b1;
            sda_s    <= 1'b1;
        end else begin
            scl_meta <= scl_in;
            scl_s    <= scl_meta;
            sda_meta <= sda_in;
            sda_s    <= sda_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clkdiv <= DIV_RST;
        end else if (div_wr) begin
            clkdiv <= (writedata[15:0] < DIV_MIN) ? DIV_MIN : writedata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            q        <= 2'd0;
            bit_idx  <= 4'd0;
            cnt      <= '0;
            busy     <= 1'b0;
            tx_byte  <= '0;
            stop_req <= 1'b0;
            rd_req   <= 1'b0;
            nack_bit <= 1'b0;
            shreg    <= '0;
            rxdata   <= '0;
            rx_ack   <= 1'b0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
        end else begin
            state    <= state_n;
            q        <= q_n;
            bit_idx  <= bit_n;
            cnt      <= cnt_n;
            busy     <= busy_n;
            tx_byte  <= tx_n;
            stop_req <= stop_n;
            rd_req   <= rd_n;
            nack_bit <= nack_n;
            shreg    <= shreg_n;
            rxdata   <= rxdata_n;
            rx_ack   <= rx_ack_n;
            scl_oe   <= scl_oe_n;
            sda_oe   <= sda_oe_n;
        end
    end

    always_comb begin
        state_n  = state;
        q_n      = q;
        bit_n    = bit_idx;
        cnt_n    = cnt;
        busy_n   = busy;
        tx_n     = tx_byte;
        stop_n   = stop_req;
        rd_n     = rd_req;
        nack_n   = nack_bit;
        shreg_n  = shreg;
        rxdata_n = rxdata;
        rx_ack_n = rx_ack;
        scl_oe_n = scl_oe;
        sda_oe_n = sda_oe;
        enter    = 1'b0;

        // Quarters in which the released SCL may be held low by the target
        stretch_q = ((state == S_START) && (q == 2'd1)) ||
                    (((state == S_BIT) || (state == S_STOP)) && (q == 2'd2));

        if (state == S_IDLE) begin
            if (cmd_wr) begin
                tx_n    = writedata[7:0];
                stop_n  = writedata[9];
                rd_n    = writedata[10];
                nack_n  = writedata[11];
                state_n = writedata[8] ? S_START : S_BIT;
                q_n     = 2'd0;
                bit_n   = 4'd0;
                cnt_n   = clkdiv;
                busy_n  = 1'b1;
                enter   = 1'b1;
            end
        end else if (stretch_q && !scl_s) begin
            // Target holds SCL: freeze the timer, including its terminal count
        end else if (cnt != 16'd0) begin
            cnt_n = cnt - 16'd1;
        end else begin
            cnt_n = clkdiv;
            q_n   = q + 2'd1;
            enter = 1'b1;
            if ((state == S_BIT) && (q == 2'd2)) begin
                if (bit_idx == 4'd8) begin
                    if (!rd_req) begin
                        rx_ack_n = sda_s;
                    end
                end else if (rd_req) begin
                    shreg_n = {shreg[6:0], sda_s};
                end
            end
            if (q == 2'd3) begin
                case (state)
                    S_START: begin
                        state_n = S_BIT;
                        bit_n   = 4'd0;
                    end
                    S_BIT: begin
                        if ((bit_idx == 4'd7) && rd_req) begin
                            rxdata_n = shreg;
                        end
                        if (bit_idx == 4'd8) begin
                            state_n = stop_req ? S_STOP : S_IDLE;
                        end else begin
                            bit_n = bit_idx + 4'd1;
                        end
                    end
                    default: state_n = S_IDLE;
                endcase
                if (state_n == S_IDLE) begin
                    busy_n = 1'b0;
                    enter  = 1'b0;
                end
            end
        end

        // Pin actions happen once, on entry to each quarter; pins otherwise hold,
        // which also leaves SCL low / SDA unchanged in IDLE when no STOP was issued.
        if (enter) begin
            case (state_n)
                S_START: begin
                    case (q_n)
                        2'd0: begin
                            scl_oe_n = 1'b0;
                            sda_oe_n = 1'b0;
                        end
                        2'd2:    sda_oe_n = 1'b1;
                        2'd3:    scl_oe_n = 1'b1;
                        default: ;
                    endcase
                end
                S_BIT: begin
                    case (q_n)
                        2'd0: begin
                            scl_oe_n = 1'b1;
                            if (bit_n == 4'd8) begin
                                sda_oe_n = rd_n ? ~nack_n : 1'b0;
                            end else begin
                                sda_oe_n = rd_n ? 1'b0 : ~tx_n[3'd7 - bit_n[2:0]];
                            end
                        end
                        2'd1:    scl_oe_n = 1'b0;
                        2'd3:    scl_oe_n = 1'b1;
                        default: ;
                    endcase
                end
                S_STOP: begin
                    case (q_n)
                        2'd0: begin
                            scl_oe_n = 1'b1;
                            sda_oe_n = 1'b1;
                        end
                        2'd1:    scl_oe_n = 1'b0;
                        2'd3:    sda_oe_n = 1'b0;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd1:    readdata[1:0]  = {rx_ack, busy};
            2'd2:    readdata[7:0]  = rxdata;
            2'd3:    readdata[15:0] = clkdiv;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ddr2_i2c_byte_master.sv
// tb_ddr2_i2c_byte_master
//   Directed bench for ddr2_i2c_byte_master with an open-drain bus model and a
//   simple target that pulls SDA according to a per-bit pattern and can
//   stretch SCL.
`timescale 1ns/1ps
module tb_ddr2_i2c_byte_master;

    localparam int unsigned DEF_DIV = 124;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        scl_oe, sda_oe;
    logic        scl_bus, sda_bus;

    logic        tgt_hold   = 1'b0;
    logic        in_stretch = 1'b0;
    logic [8:0]  tgt_pat    = '0;
    int          tgt_off    = 0;
    int          base_fall  = 0;
    int          base_rise  = 0;
    int          tgt_idx;
    logic        tgt_low;

    int          rise_n = 0;
    int          fall_n = 0;
    int          stop_n = 0;
    logic        cap [512];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc;
    int          stop0;
    int          st_wait;
    logic [31:0] d;

    always #5 clk = ~clk;

    assign scl_bus = ~scl_oe & ~tgt_hold;
    assign sda_bus = ~sda_oe & ~tgt_low;

    // Target SDA pull: bit k of tgt_pat is driven while the bus is in bit k,
    // tracked by SCL falling edges since the command was issued.
    assign tgt_idx = fall_n - base_fall - tgt_off;
    assign tgt_low = (tgt_idx >= 0 && tgt_idx <= 8) ? tgt_pat[tgt_idx[3:0]] : 1'b0;

    ddr2_i2c_byte_master #(.DEFAULT_DIV(DEF_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .scl_in     (scl_bus),
        .sda_in     (sda_bus),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe)
    );

    always @(posedge scl_bus) begin
        if (!in_stretch) begin
            if (rise_n < 512) cap[rise_n] <= sda_bus;
            rise_n <= rise_n + 1;
        end
    end

    always @(negedge scl_bus) begin
        if (!in_stretch) fall_n <= fall_n + 1;
    end

    always @(posedge sda_bus) begin
        if (scl_bus === 1'b1) stop_n <= stop_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Call while clk is low; returns on the following negedge.
    task automatic wr(input logic [1:0] a, input logic [31:0] dat);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = dat;
        @(negedge clk);
        write_n    = 1'b1;
        address    = 2'd1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] dat);
        address    = a;
        chipselect = 1'b1;
        #1;
        dat        = readdata;
        address    = 2'd1;
    endtask

    // Counts negedges with busy=1, starting at the current negedge.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        address = 2'd1;
        #1;
        while (readdata[0] === 1'b1 && cycles < 5000) begin
            cycles++;
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] get_byte(input int b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = cap[b+i];
        return r;
    endfunction

    task automatic arm_target(input int off, input logic [8:0] pat);
        base_rise = rise_n;
        base_fall = fall_n;
        tgt_off   = off;
        tgt_pat   = pat;
        stop0     = stop_n;
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        #1;
        check("rst_pins", {30'd0, scl_oe, sda_oe}, 32'h0);
        rd(2'd1, d); check("rst_status", d, 32'h0);
        rd(2'd2, d); check("rst_rxdata", d, 32'h0);
        rd(2'd3, d); check("rst_clkdiv", d, DEF_DIV);
        rd(2'd0, d); check("rst_cmd_reads0", d, 32'h0);

        // Write 0xA0 with START, target ACKs
        @(negedge clk);
        wr(2'd3, 32'd4);
        rd(2'd3, d); check("clkdiv_4", d, 32'd4);
        arm_target(1, 9'h100);
        wr(2'd0, 32'h1A0);
        wait_idle(cyc);
        check("wr_busy_cycles", cyc, 200);
        rd(2'd1, d); check("wr_status", d, 32'h0);
        check("wr_sda_bits", get_byte(base_rise), 8'hA0);
        check("wr_ack_bit", cap[base_rise+8], 1'b0);
        check("wr_scl_held", scl_oe, 1'b1);

        // Read 0x5A with NACK and STOP
        @(negedge clk);
        arm_target(0, 9'h0A5);
        wr(2'd0, 32'hE00);
        wait_idle(cyc);
        check("rd_busy_cycles", cyc, 200);
        rd(2'd2, d); check("rd_rxdata", d, 32'h5A);
        check("rd_bus_bits", get_byte(base_rise), 8'h5A);
        check("rd_nack_released", cap[base_rise+8], 1'b1);
        check("rd_stop_seen", stop_n - stop0, 1);
        check("rd_pins_released", {30'd0, scl_oe, sda_oe}, 32'h0);

        // Write 0x55 with START|STOP, target does not ACK
        @(negedge clk);
        arm_target(1, 9'h000);
        wr(2'd0, 32'h355);
        wait_idle(cyc);
        check("nack_busy_cycles", cyc, 220);
        rd(2'd1, d); check("nack_status", d, 32'h2);
        check("nack_sda_bits", get_byte(base_rise), 8'h55);
        check("nack_stop_seen", stop_n - stop0, 1);

        // Clock stretch: 50-cycle hold in bit 3, applied once the master's
        // release has reached the synchroniser so all 50 cycles fall in q2.
        @(negedge clk);
        arm_target(1, 9'h100);
        fork
            begin
                wr(2'd0, 32'h1A0);
                wait_idle(cyc);
            end
            begin
                st_wait = 0;
                while (rise_n != base_rise + 4 && st_wait < 2000) begin
                    @(negedge clk);
                    st_wait++;
                end
                if (st_wait < 2000) begin
                    repeat (3) @(negedge clk);
                    in_stretch = 1'b1;
                    tgt_hold   = 1'b1;
                    repeat (50) @(negedge clk);
                    tgt_hold   = 1'b0;
                    #1;
                    in_stretch = 1'b0;
                end
            end
        join
        check("stretch_busy_cycles", cyc, 250);
        rd(2'd1, d); check("stretch_status", d, 32'h0);
        check("stretch_sda_bits", get_byte(base_rise), 8'hA0);

        // Busy lockout: CLKDIV and CMD writes during a transfer are dropped
        @(negedge clk);
        arm_target(0, 9'h100);
        wr(2'd0, 32'h200);
        wr(2'd3, 32'd10);
        wr(2'd0, 32'h1FF);
        rd(2'd3, d); check("lock_clkdiv", d, 32'd4);
        wait_idle(cyc);
        check("lock_busy_cycles", cyc + 2, 200);
        check("lock_sda_bits", get_byte(base_rise), 8'h00);
        @(negedge clk);
        rd(2'd1, d); check("lock_no_retrigger", d, 32'h0);

        // CLKDIV clamp
        @(negedge clk);
        wr(2'd3, 32'd1);
        rd(2'd3, d); check("clamp_1_to_4", d, 32'd4);
        wr(2'd3, 32'd7);
        rd(2'd3, d); check("clkdiv_7", d, 32'd7);
        wr(2'd3, 32'd4);

        // Reset during BIT 4 q0 (SCL low, SDA driven low for tx bit 0)
        @(negedge clk);
        arm_target(1, 9'h100);
        wr(2'd0, 32'h1A0);
        st_wait = 0;
        while (rise_n != base_rise + 4 && st_wait < 2000) begin
            @(negedge clk);
            st_wait++;
        end
        repeat (16) @(negedge clk);
        #1;
        check("pre_reset_pins", {30'd0, scl_oe, sda_oe}, 32'h3);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_pins", {30'd0, scl_oe, sda_oe}, 32'h0);
        rd(2'd1, d); check("midrst_status", d, 32'h0);
        rd(2'd3, d); check("midrst_clkdiv", d, DEF_DIV);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
